// File: rtl/stop_watch_disp_pkg.sv
// Shared constants for the stopwatch display multiplexer: segment patterns,
// digit-enable codes and the refresh slot encoding.
package stop_watch_disp_pkg;

  // Segment bus is {dp,g,f,e,d,c,b,a}, active-low.
  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  // Digit enables, active-low.
  localparam logic [3:0] AN_OFF = 4'b1111;
  localparam logic [3:0] AN_D0  = 4'b1110;
  localparam logic [3:0] AN_D1  = 4'b1101;
  localparam logic [3:0] AN_D2  = 4'b1011;

  // Refresh slot taken from the top two bits of the refresh counter.
  typedef enum logic [1:0] {
    SLOT_D0 = 2'b00,
    SLOT_D1 = 2'b01,
    SLOT_D2 = 2'b10,
    SLOT_D3 = 2'b11
  } slot_e;

endpackage

// File: rtl/stop_watch_disp_mux_bcd_to_sseg.sv
// BCD to active-low 7-segment decoder {g,f,e,d,c,b,a}.
// Codes 10-15 are not valid BCD and are shown as a dash (only g lit).
module bcd_to_sseg
  import stop_watch_disp_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  // Digit pattern lookup; anything outside 0-9 falls through to the dash.
  always_comb begin
    seg = SEG_DASH;
    case (bcd)
      4'd0:    seg = 7'b1000000;
      4'd1:    seg = 7'b1111001;
      4'd2:    seg = 7'b0100100;
      4'd3:    seg = 7'b0110000;
      4'd4:    seg = 7'b0011001;
      4'd5:    seg = 7'b0010010;
      4'd6:    seg = 7'b0000010;
      4'd7:    seg = 7'b1111000;
      4'd8:    seg = 7'b0000000;
      4'd9:    seg = 7'b0010000;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/stop_watch_disp_mux.sv
// Time-multiplexed 4-digit 7-segment driver for the BCD stopwatch.
// Shows "d2 d1 . d0"; digits are snapshotted at the end of each refresh
// frame so a frame never mixes old and new values. d2 is blanked when zero
// and the fourth digit is always dark.
// Optional feature macro STOP_WATCH_DISP_BLINK_EN: blink the whole display
// while the stopwatch is paused (go==0). Without it, go is ignored.
module stop_watch_disp_mux
  import stop_watch_disp_pkg::*;
#(
  parameter int N       = 18,
  parameter int BLINK_B = 24
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] d2,
  input  logic [3:0] d1,
  input  logic [3:0] d0,
  input  logic       go,
  output logic [3:0] an,
  output logic [7:0] sseg
);

  localparam logic [N-1:0] Q_ONE = {{(N-1){1'b0}}, 1'b1};
  localparam logic [N-1:0] Q_MAX = {N{1'b1}};

  logic [N-1:0] q_q, q_d;
  logic [3:0]   s2_q, s2_d, s1_q, s1_d, s0_q, s0_d;
  logic [3:0]   an_q, an_d;
  logic [7:0]   sseg_q, sseg_d;

  slot_e        sel_s;
  logic [3:0]   digit_s;
  logic [6:0]   seg_s;
  logic         dp_s;
  logic [3:0]   an_sel_s;
  logic         blank_s;
  logic         blink_s;

  // Refresh counter advance and end-of-frame digit snapshot.
  always_comb begin
    q_d  = q_q + Q_ONE;
    s2_d = s2_q;
    s1_d = s1_q;
    s0_d = s0_q;
    if (q_q == Q_MAX) begin
      s2_d = d2;
      s1_d = d1;
      s0_d = d0;
    end else begin
      s2_d = s2_q;
      s1_d = s1_q;
      s0_d = s0_q;
    end
  end

  assign sel_s = slot_e'(q_q[N-1:N-2]);

  // Pick the snapshot digit, its enable and decimal point for the current slot.
  always_comb begin
    digit_s  = 4'd0;
    dp_s     = 1'b1;
    an_sel_s = AN_OFF;
    blank_s  = 1'b1;
    case (sel_s)
      SLOT_D0: begin
        digit_s  = s0_q;
        an_sel_s = AN_D0;
        blank_s  = 1'b0;
      end
      SLOT_D1: begin
        digit_s  = s1_q;
        an_sel_s = AN_D1;
        dp_s     = 1'b0;
        blank_s  = 1'b0;
      end
      SLOT_D2: begin
        digit_s  = s2_q;
        an_sel_s = AN_D2;
        blank_s  = (s2_q == 4'd0);
      end
      SLOT_D3: begin
        blank_s  = 1'b1;
      end
      default: begin
        blank_s  = 1'b1;
      end
    endcase
  end

  bcd_to_sseg u_dec (
    .bcd (digit_s),
    .seg (seg_s)
  );

`ifdef STOP_WATCH_DISP_BLINK_EN
  logic [BLINK_B-1:0] bc_q, bc_d;

  // Free-running blink timebase.
  always_comb begin
    bc_d = bc_q + {{(BLINK_B-1){1'b0}}, 1'b1};
  end

  // Blink timebase register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bc_q <= '0;
    end else begin
      bc_q <= bc_d;
    end
  end

  assign blink_s = ~go & bc_q[BLINK_B-1];
`else
  logic unused_go_s;
  assign unused_go_s = go & (BLINK_B > 0);
  assign blink_s     = 1'b0;
`endif

  // Final output selection: blanked slots and blink phase force all segments off.
  always_comb begin
    an_d   = AN_OFF;
    sseg_d = SEG_BLANK;
    if (blank_s || blink_s) begin
      an_d   = AN_OFF;
      sseg_d = SEG_BLANK;
    end else begin
      an_d   = an_sel_s;
      sseg_d = {dp_s, seg_s};
    end
  end

  // State and output registers; reset shows a dark display.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q_q    <= '0;
      s2_q   <= 4'd0;
      s1_q   <= 4'd0;
      s0_q   <= 4'd0;
      an_q   <= AN_OFF;
      sseg_q <= SEG_BLANK;
    end else begin
      q_q    <= q_d;
      s2_q   <= s2_d;
      s1_q   <= s1_d;
      s0_q   <= s0_d;
      an_q   <= an_d;
      sseg_q <= sseg_d;
    end
  end

  assign an   = an_q;
  assign sseg = sseg_q;

endmodule

// File: tb/tb_stop_watch_disp_mux.sv
// Directed self-checking bench for stop_watch_disp_mux (N=4, BLINK_B=6).
// k counts rising edges since the last reset release; outputs are sampled on
// the falling edge after edge k and then reflect refresh count q=(k-1) mod 16.
module tb_stop_watch_disp_mux;

  localparam int N       = 4;
  localparam int BLINK_B = 6;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [3:0] d2, d1, d0;
  logic       go;
  logic [3:0] an;
  logic [7:0] sseg;

  int total = 0;
  int bad   = 0;
  int k     = 0;

  always #5 clk = ~clk;

  stop_watch_disp_mux #(.N(N), .BLINK_B(BLINK_B)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .d2      (d2),
    .d1      (d1),
    .d0      (d0),
    .go      (go),
    .an      (an),
    .sseg    (sseg)
  );

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      k++;
      @(negedge clk);
    end
  endtask

  task automatic goto_k(input int t);
    while (k < t) step(1);
  endtask

  // First edge index whose sample shows slot 0 of the frame after the next snapshot.
  function automatic int next_base(input int kk);
    return (kk / 16 + 1) * 16 + 1;
  endfunction

  task automatic test_reset;
    reset_n = 1'b0; d2 = 4'd9; d1 = 4'd9; d0 = 4'd9; go = 1'b1;
    repeat (3) @(negedge clk);
    total++; if (an !== 4'b1111 || sseg !== 8'hFF) begin bad++; $display("FAIL reset_hold an=%b sseg=%h want 1111/ff", an, sseg); end
    reset_n = 1'b1; k = 0;
    total++; if (an !== 4'b1111 || sseg !== 8'hFF) begin bad++; $display("FAIL reset_release an=%b sseg=%h want 1111/ff", an, sseg); end
    step(1);
    total++; if (an !== 4'b1110 || sseg !== 8'hC0) begin bad++; $display("FAIL rst_slot0 an=%b sseg=%h want 1110/c0", an, sseg); end
    goto_k(5);
    total++; if (an !== 4'b1101 || sseg !== 8'h40) begin bad++; $display("FAIL rst_slot1 an=%b sseg=%h want 1101/40", an, sseg); end
    goto_k(9);
    total++; if (an !== 4'b1111 || sseg !== 8'hFF) begin bad++; $display("FAIL rst_slot2 an=%b sseg=%h want 1111/ff", an, sseg); end
    goto_k(13);
    total++; if (an !== 4'b1111 || sseg !== 8'hFF) begin bad++; $display("FAIL rst_slot3 an=%b sseg=%h want 1111/ff", an, sseg); end
    goto_k(17);
    total++; if (an !== 4'b1110 || sseg !== 8'h90) begin bad++; $display("FAIL snap9_slot0 an=%b sseg=%h want 1110/90", an, sseg); end
    goto_k(21);
    total++; if (an !== 4'b1101 || sseg !== 8'h10) begin bad++; $display("FAIL snap9_slot1 an=%b sseg=%h want 1101/10", an, sseg); end
    goto_k(25);
    total++; if (an !== 4'b1011 || sseg !== 8'h90) begin bad++; $display("FAIL snap9_slot2 an=%b sseg=%h want 1011/90", an, sseg); end
  endtask

  task automatic test_digits;
    int b;
    d2 = 4'd1; d1 = 4'd2; d0 = 4'd3;
    b = next_base(k);
    for (int f = 0; f < 2; f++) begin
      goto_k(b + 16 * f);
      total++; if (an !== 4'b1110 || sseg !== 8'hB0) begin bad++; $display("FAIL dig_slot0 f=%0d an=%b sseg=%h want 1110/b0", f, an, sseg); end
      goto_k(b + 16 * f + 3);
      total++; if (an !== 4'b1110 || sseg !== 8'hB0) begin bad++; $display("FAIL dig_slot0_end f=%0d an=%b sseg=%h want 1110/b0", f, an, sseg); end
      goto_k(b + 16 * f + 4);
      total++; if (an !== 4'b1101 || sseg !== 8'h24) begin bad++; $display("FAIL dig_slot1 f=%0d an=%b sseg=%h want 1101/24", f, an, sseg); end
      goto_k(b + 16 * f + 8);
      total++; if (an !== 4'b1011 || sseg !== 8'hF9) begin bad++; $display("FAIL dig_slot2 f=%0d an=%b sseg=%h want 1011/f9", f, an, sseg); end
      goto_k(b + 16 * f + 12);
      total++; if (an !== 4'b1111 || sseg !== 8'hFF) begin bad++; $display("FAIL dig_slot3 f=%0d an=%b sseg=%h want 1111/ff", f, an, sseg); end
    end
  endtask

  task automatic test_leading_zero;
    int b;
    d2 = 4'd0; d1 = 4'd0; d0 = 4'd7;
    b = next_base(k);
    goto_k(b);
    total++; if (an !== 4'b1110 || sseg !== 8'hF8) begin bad++; $display("FAIL lz_slot0 an=%b sseg=%h want 1110/f8", an, sseg); end
    goto_k(b + 4);
    total++; if (an !== 4'b1101 || sseg !== 8'h40) begin bad++; $display("FAIL lz_slot1 an=%b sseg=%h want 1101/40", an, sseg); end
    goto_k(b + 8);
    total++; if (an !== 4'b1111 || sseg !== 8'hFF) begin bad++; $display("FAIL lz_slot2 an=%b sseg=%h want 1111/ff", an, sseg); end
    goto_k(b + 12);
    total++; if (an !== 4'b1111 || sseg !== 8'hFF) begin bad++; $display("FAIL lz_slot3 an=%b sseg=%h want 1111/ff", an, sseg); end
  endtask

  task automatic test_midframe_change;
    int b;
    d2 = 4'd1; d1 = 4'd2; d0 = 4'd3;
    b = next_base(k);
    goto_k(b);
    total++; if (sseg !== 8'hB0) begin bad++; $display("FAIL mf_before sseg=%h want b0", sseg); end
    goto_k(b + 1);
    d0 = 4'd4;
    goto_k(b + 3);
    total++; if (an !== 4'b1110 || sseg !== 8'hB0) begin bad++; $display("FAIL mf_hold an=%b sseg=%h want 1110/b0", an, sseg); end
    goto_k(b + 16);
    total++; if (an !== 4'b1110 || sseg !== 8'h99) begin bad++; $display("FAIL mf_after an=%b sseg=%h want 1110/99", an, sseg); end
    // Change twice; the second change lands inside the snapshot cycle.
    goto_k(b + 29);
    d0 = 4'd6;
    goto_k(b + 30);
    d0 = 4'd5;
    goto_k(b + 32);
    total++; if (an !== 4'b1110 || sseg !== 8'h92) begin bad++; $display("FAIL mf_snapcycle an=%b sseg=%h want 1110/92", an, sseg); end
  endtask

  task automatic test_invalid_bcd;
    int b;
    d2 = 4'hA; d1 = 4'hF; d0 = 4'hC;
    b = next_base(k);
    goto_k(b);
    total++; if (an !== 4'b1110 || sseg !== 8'hBF) begin bad++; $display("FAIL inv_slot0 an=%b sseg=%h want 1110/bf", an, sseg); end
    goto_k(b + 4);
    total++; if (an !== 4'b1101 || sseg !== 8'h3F) begin bad++; $display("FAIL inv_slot1 an=%b sseg=%h want 1101/3f", an, sseg); end
    goto_k(b + 8);
    total++; if (an !== 4'b1011 || sseg !== 8'hBF) begin bad++; $display("FAIL inv_slot2 an=%b sseg=%h want 1011/bf", an, sseg); end
  endtask

  task automatic test_midframe_reset;
    int b;
    d2 = 4'd1; d1 = 4'd2; d0 = 4'd3;
    b = next_base(k);
    goto_k(b + 5);
    total++; if (an !== 4'b1101 || sseg !== 8'h24) begin bad++; $display("FAIL mr_pre an=%b sseg=%h want 1101/24", an, sseg); end
    #2;
    reset_n = 1'b0;
    #1;
    total++; if (an !== 4'b1111 || sseg !== 8'hFF) begin bad++; $display("FAIL mr_async an=%b sseg=%h want 1111/ff", an, sseg); end
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1; k = 0;
    step(1);
    total++; if (an !== 4'b1110 || sseg !== 8'hC0) begin bad++; $display("FAIL mr_slot0 an=%b sseg=%h want 1110/c0", an, sseg); end
    goto_k(5);
    total++; if (an !== 4'b1101 || sseg !== 8'h40) begin bad++; $display("FAIL mr_slot1 an=%b sseg=%h want 1101/40", an, sseg); end
  endtask

  // Runs right after test_midframe_reset: k counts from that release, snapshot holds 1,2,3.
  task automatic test_go;
    go = 1'b0;
    goto_k(17);
    total++; if (an !== 4'b1110 || sseg !== 8'hB0) begin bad++; $display("FAIL go0_lowphase an=%b sseg=%h want 1110/b0", an, sseg); end
`ifdef STOP_WATCH_DISP_BLINK_EN
    goto_k(33);
    total++; if (an !== 4'b1111 || sseg !== 8'hFF) begin bad++; $display("FAIL go0_blink_s0 an=%b sseg=%h want 1111/ff", an, sseg); end
    goto_k(37);
    total++; if (an !== 4'b1111 || sseg !== 8'hFF) begin bad++; $display("FAIL go0_blink_s1 an=%b sseg=%h want 1111/ff", an, sseg); end
`else
    goto_k(33);
    total++; if (an !== 4'b1110 || sseg !== 8'hB0) begin bad++; $display("FAIL go0_noblink_s0 an=%b sseg=%h want 1110/b0", an, sseg); end
    goto_k(37);
    total++; if (an !== 4'b1101 || sseg !== 8'h24) begin bad++; $display("FAIL go0_noblink_s1 an=%b sseg=%h want 1101/24", an, sseg); end
`endif
    goto_k(65);
    total++; if (an !== 4'b1110 || sseg !== 8'hB0) begin bad++; $display("FAIL go0_wrap an=%b sseg=%h want 1110/b0", an, sseg); end
    go = 1'b1;
    goto_k(97);
    total++; if (an !== 4'b1110 || sseg !== 8'hB0) begin bad++; $display("FAIL go1_s0 an=%b sseg=%h want 1110/b0", an, sseg); end
    goto_k(101);
    total++; if (an !== 4'b1101 || sseg !== 8'h24) begin bad++; $display("FAIL go1_s1 an=%b sseg=%h want 1101/24", an, sseg); end
  endtask

  initial begin
    test_reset();
    test_digits();
    test_leading_zero();
    test_midframe_change();
    test_invalid_bcd();
    test_midframe_reset();
    test_go();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
